// File: rtl/timer_pkg.sv
// Shared definitions for the timer bank: register offsets inside a channel
// window, TCON bit positions and the STATUS register offset.
package timer_pkg;

    // Byte offsets of the registers inside one 16-byte channel window.
    localparam logic [3:0] OFF_TH   = 4'h0;
    localparam logic [3:0] OFF_TL   = 4'h4;
    localparam logic [3:0] OFF_TCON = 4'h8;
    localparam logic [3:0] OFF_PSC  = 4'hC;

    // STATUS sits past the last possible channel window.
    localparam logic [31:0] STATUS_OFF = 32'h0000_0080;

    // TCON layout.
    localparam int TCON_EN      = 0;
    localparam int TCON_IRQ_EN  = 1;
    localparam int TCON_ONESHOT = 2;
    localparam int TCON_W       = 3;

    localparam int PSC_W = 16;

    // Register select decoded from addr[3:2] of a channel window.
    typedef enum logic [1:0] {
        REG_TH   = OFF_TH[3:2],
        REG_TL   = OFF_TL[3:2],
        REG_TCON = OFF_TCON[3:2],
        REG_PSC  = OFF_PSC[3:2]
    } reg_sel_e;

endpackage

// File: rtl/timer_bank_if.sv
// Register bus between a host and the timer bank.
// Protocol: rd and wr are single-cycle strobes with no ready/wait; every
// access completes in the cycle it is presented. Writes take effect on the
// next rising clock edge, read data is valid combinationally in the same
// cycle that rd is high and is 0 otherwise.
interface timer_bank_if;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output rd, output wr, output addr, output wdata, input rdata);
    modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/timer_channel.sv
// One timer channel: reload (TH), counter (TL), control (TCON), optional
// prescaler (PSC) and overflow detection. Optional feature macro:
// TIMER_PRESCALER_EN enables the 16-bit prescaler; without it PSC reads 0.
module timer_channel
    import timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                sysclk,
    input  logic                reset,
    input  logic                wr_th,
    input  logic                wr_tl,
    input  logic                wr_tcon,
    input  logic                wr_psc,
    input  logic [31:0]         wdata,
    output logic [CNT_W-1:0]    th,
    output logic [CNT_W-1:0]    tl,
    output logic [TCON_W-1:0]   tcon,
    output logic [PSC_W-1:0]    psc,
    output logic                ovf,
    output logic                tick
);

    logic step;
    logic adv;

    // A bus write to TL or TCON owns this channel for the cycle, so counting
    // (and therefore overflow, reload and one-shot clear) is held off.
    assign adv = step && !wr_tl && !wr_tcon;
    assign ovf = adv && (tl == '1);

`ifdef TIMER_PRESCALER_EN
    logic [PSC_W-1:0] psc_q;
    logic [PSC_W-1:0] pcnt_q;

    assign psc  = psc_q;
    assign step = tcon[TCON_EN] && (pcnt_q == psc_q);

    // Prescaler: divide enabled cycles by PSC+1, restart on TCON/PSC writes.
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            psc_q  <= '0;
            pcnt_q <= '0;
        end else begin
            if (wr_psc) psc_q <= wdata[PSC_W-1:0];
            if (wr_tcon || wr_psc) pcnt_q <= '0;
            else if (tcon[TCON_EN]) pcnt_q <= (pcnt_q == psc_q) ? '0 : pcnt_q + 16'd1;
        end
    end
`else
    assign psc  = '0;
    assign step = tcon[TCON_EN];
`endif

    // Bits of the write bus not every register needs.
    logic unused_in;
    assign unused_in = ^{wdata, wr_psc};

    // Register file, counter with reload, one-shot handling and tick pulse.
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            th   <= '0;
            tl   <= '0;
            tcon <= '0;
            tick <= 1'b0;
        end else begin
            if (wr_th) th <= wdata[CNT_W-1:0];
            if (wr_tl) tl <= wdata[CNT_W-1:0];
            else if (adv) tl <= ovf ? th : tl + CNT_W'(1);
            if (wr_tcon) tcon <= wdata[TCON_W-1:0];
            else if (ovf && tcon[TCON_ONESHOT]) tcon[TCON_EN] <= 1'b0;
            tick <= ovf;
        end
    end

endmodule

// File: rtl/timer_bank.sv
// Bank of N_CH timers behind a simple rd/wr register bus. The top does the
// address decode, holds the write-1-to-clear STATUS register, muxes read
// data and forms the interrupt. Optional feature macro: TIMER_PRESCALER_EN
// (per-channel prescaler, implemented in timer_channel).
module timer_bank
    import timer_pkg::*;
#(
    parameter int          N_CH      = 4,
    parameter int          CNT_W     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0100
) (
    input  logic            sysclk,
    input  logic            reset,
    timer_bank_if.slave     bus,
    input  logic            PC_31,
    output logic            irqout,
    output logic [N_CH-1:0] tick
);

    logic [31:0]       off;
    logic [2:0]        ch_idx;
    reg_sel_e          reg_sel;
    logic              ch_hit;
    logic              status_hit;

    assign off        = bus.addr - BASE_ADDR;
    assign ch_idx     = off[6:4];
    assign reg_sel    = reg_sel_e'(off[3:2]);
    assign ch_hit     = (off[31:7] == '0) && (off[1:0] == 2'b00) &&
                        ({29'd0, ch_idx} < 32'(N_CH));
    assign status_hit = (off == STATUS_OFF);

    logic [CNT_W-1:0]  th_a   [N_CH];
    logic [CNT_W-1:0]  tl_a   [N_CH];
    logic [TCON_W-1:0] tcon_a [N_CH];
    logic [PSC_W-1:0]  psc_a  [N_CH];
    logic [N_CH-1:0]   ovf_v;
    logic [N_CH-1:0]   irq_en_v;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic wr_ch;
        assign wr_ch       = bus.wr && ch_hit && (ch_idx == 3'(i));
        assign irq_en_v[i] = tcon_a[i][TCON_IRQ_EN];

        timer_channel #(.CNT_W(CNT_W)) u_ch (
            .sysclk  (sysclk),
            .reset   (reset),
            .wr_th   (wr_ch && (reg_sel == REG_TH)),
            .wr_tl   (wr_ch && (reg_sel == REG_TL)),
            .wr_tcon (wr_ch && (reg_sel == REG_TCON)),
            .wr_psc  (wr_ch && (reg_sel == REG_PSC)),
            .wdata   (bus.wdata),
            .th      (th_a[i]),
            .tl      (tl_a[i]),
            .tcon    (tcon_a[i]),
            .psc     (psc_a[i]),
            .ovf     (ovf_v[i]),
            .tick    (tick[i])
        );
    end

    logic [N_CH-1:0] status_q;
    logic [N_CH-1:0] w1c;

    assign w1c = (bus.wr && status_hit) ? bus.wdata[N_CH-1:0] : '0;

    // STATUS: W1C, with a same-cycle overflow winning over the clear.
    always_ff @(posedge sysclk) begin
        if (!reset) status_q <= '0;
        else        status_q <= (status_q & ~w1c) | ovf_v;
    end

    logic [31:0] rdata_c;

    // Zero-latency read mux; unmapped or idle reads return 0.
    always_comb begin
        rdata_c = '0;
        if (bus.rd) begin
            if (status_hit) begin
                rdata_c = 32'(status_q);
            end else if (ch_hit) begin
                for (int i = 0; i < N_CH; i++) begin
                    if (ch_idx == 3'(i)) begin
                        case (reg_sel)
                            REG_TH:   rdata_c = 32'(th_a[i]);
                            REG_TL:   rdata_c = 32'(tl_a[i]);
                            REG_TCON: rdata_c = 32'(tcon_a[i]);
                            REG_PSC:  rdata_c = 32'(psc_a[i]);
                            default:  rdata_c = '0;
                        endcase
                    end
                end
            end
        end
    end

    assign bus.rdata = rdata_c;
    assign irqout    = ~PC_31 & |(status_q & irq_en_v);

endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank: directed scenarios followed by random
// bus traffic, all compared against a cycle-level behavioural model.
// Optional feature macro: TIMER_PRESCALER_EN.
module tb_timer_bank;

    localparam int          N_CH     = 4;
    localparam int          CNT_W    = 32;
    localparam logic [31:0] BASE     = 32'h4000_0100;
    localparam logic [31:0] STATUS_A = BASE + 32'h80;
    localparam logic [31:0] CNT_MASK = 32'((64'd1 << CNT_W) - 64'd1);

    // ---------------- clock / reset ----------------
    logic            sysclk = 1'b0;
    logic            reset;
    logic            pc_31;
    logic            irqout;
    logic [N_CH-1:0] tick;

    always #5 sysclk = ~sysclk;

    timer_bank_if bus_if ();

    timer_bank #(.N_CH(N_CH), .CNT_W(CNT_W), .BASE_ADDR(BASE)) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (bus_if.slave),
        .PC_31  (pc_31),
        .irqout (irqout),
        .tick   (tick)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0]     m_th    [N_CH];
    logic [31:0]     m_tl    [N_CH];
    logic [2:0]      m_tcon  [N_CH];
    logic [15:0]     m_psc   [N_CH];
    int              m_encnt [N_CH];   // enabled cycles since last TCON/PSC write
    logic [N_CH-1:0] m_status;
    logic [N_CH-1:0] m_tick;

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_th[i] = 0; m_tl[i] = 0; m_tcon[i] = 0; m_psc[i] = 0; m_encnt[i] = 0;
        end
        m_status = '0;
        m_tick   = '0;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] off;
        int ch, r;
        off = a - BASE;
        if (off == 32'h80) return 32'(m_status);
        if (off < 32'(16 * N_CH) && (off % 4) == 0) begin
            ch = int'(off / 16);
            r  = int'((off % 16) / 4);
            case (r)
                0: return m_th[ch];
                1: return m_tl[ch];
                2: return 32'(m_tcon[ch]);
                default: return 32'(m_psc[ch]);
            endcase
        end
        return 0;
    endfunction

    function automatic logic model_irq();
        logic any_irq = 1'b0;
        for (int i = 0; i < N_CH; i++) any_irq |= m_status[i] & m_tcon[i][1];
        return !pc_31 && any_irq;
    endfunction

    // Advance the model by one clock edge given this cycle's bus inputs.
    task automatic model_step(input logic w, input logic [31:0] a, input logic [31:0] d);
        logic [N_CH-1:0] ovf = '0;
        logic [31:0] cb;
        logic wth, wtl, wtc, wps, en, slot, adv;
        for (int i = 0; i < N_CH; i++) begin
            cb   = BASE + 32'(16 * i);
            wth  = w && a == cb;
            wtl  = w && a == cb + 4;
            wtc  = w && a == cb + 8;
            wps  = w && a == cb + 12;
            en   = m_tcon[i][0];
            slot = en && ((m_encnt[i] % (int'(m_psc[i]) + 1)) == int'(m_psc[i]));
            adv  = slot && !wtl && !wtc;
            if (wtc || wps) m_encnt[i] = 0;
            else if (en)    m_encnt[i]++;
            ovf[i] = adv && m_tl[i] == CNT_MASK;
            if (wtl)      m_tl[i] = d & CNT_MASK;
            else if (adv) m_tl[i] = ovf[i] ? m_th[i] : (m_tl[i] + 1) & CNT_MASK;
            if (wtc)                        m_tcon[i] = d[2:0];
            else if (ovf[i] && m_tcon[i][2]) m_tcon[i] = m_tcon[i] & 3'b110;
            if (wth) m_th[i] = d & CNT_MASK;
`ifdef TIMER_PRESCALER_EN
            if (wps) m_psc[i] = d[15:0];
`endif
        end
        if (w && a == STATUS_A) m_status = m_status & ~d[N_CH-1:0];
        m_status = m_status | ovf;
        m_tick   = ovf;
    endtask

    // ---------------- driver ----------------
    logic [31:0]     exp_q[$];
    logic [31:0]     last_rdata;
    logic            irq_seen;
    logic [N_CH-1:0] tick_seen;
    int              tick_cnt [N_CH];

    // One bus cycle, entered and left at the falling edge.
    task automatic cycle(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        bus_if.rd = r; bus_if.wr = w; bus_if.addr = a; bus_if.wdata = d;
        if (r) exp_q.push_back(model_read(a));
        #1;
        last_rdata = bus_if.rdata;
        irq_seen   = irqout;
        if (r) check_eq("rdata", bus_if.rdata, exp_q.pop_front());
        check_eq("irqout", 32'(irqout), 32'(model_irq()));
        @(posedge sysclk);
        #1;
        model_step(w, a, d);
        tick_seen = tick;
        for (int i = 0; i < N_CH; i++) tick_cnt[i] += int'(tick[i]);
        check_eq("tick", 32'(tick), 32'(m_tick));
        @(negedge sysclk);
        bus_if.rd = 1'b0; bus_if.wr = 1'b0;
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
        cycle(1'b0, 1'b1, a, d);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        cycle(1'b1, 1'b0, a, 32'd0);
        check_eq(tag, last_rdata, exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    // One reset edge; a write presented in the same cycle must be discarded.
    task automatic apply_reset(input logic w, input logic [31:0] a, input logic [31:0] d);
        bus_if.rd = 1'b0; bus_if.wr = w; bus_if.addr = a; bus_if.wdata = d;
        reset = 1'b0;
        @(posedge sysclk);
        #1;
        model_reset();
        check_eq("rst_tick", 32'(tick), 32'd0);
        @(negedge sysclk);
        reset = 1'b1;
        bus_if.wr = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < N_CH; i++)
            for (int r = 0; r < 4; r++)
                rd_chk(tag, BASE + 32'(16 * i + 4 * r), 32'd0);
        rd_chk(tag, STATUS_A, 32'd0);
    endtask

    function automatic logic [31:0] ch_a(input int ch, input int r);
        return BASE + 32'(16 * ch + 4 * r);
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a, d;
        int k, ch, r;

        reset = 1'b0; pc_31 = 1'b0;
        bus_if.rd = 1'b0; bus_if.wr = 1'b0; bus_if.addr = '0; bus_if.wdata = '0;
        for (int i = 0; i < N_CH; i++) tick_cnt[i] = 0;
        model_reset();
        repeat (2) @(posedge sysclk);
        @(negedge sysclk);
        reset = 1'b1;
        check_eq("reset_irq", 32'(irqout), 32'd0);
        check_eq("reset_tick", 32'(tick), 32'd0);
        check_all_zero("reset_regs");

        // Overflow of channel 0 with reload and interrupt.
        wr_reg(ch_a(0, 0), 32'hFFFF_FFFC);
        wr_reg(ch_a(0, 1), 32'hFFFF_FFFC);
        wr_reg(ch_a(0, 2), 32'd3);
        for (int i = 0; i < N_CH; i++) tick_cnt[i] = 0;
        idle(3);
        check_eq("ch0_no_tick_early", 32'(tick_seen[0]), 32'd0);
        idle(1);
        check_eq("ch0_tick", 32'(tick_seen[0]), 32'd1);
        check_eq("ch0_tick_cnt", 32'(tick_cnt[0]), 32'd1);
        rd_chk("ch0_tl_reload", ch_a(0, 1), 32'hFFFF_FFFC);
        check_eq("ch0_irq", 32'(irq_seen), 32'd1);
        rd_chk("ch0_status", STATUS_A, 32'd1);
        wr_reg(ch_a(0, 2), 32'd2);

        // Supervisor mask and W1C.
        pc_31 = 1'b1; idle(1);
        check_eq("pc31_mask", 32'(irq_seen), 32'd0);
        pc_31 = 1'b0; idle(1);
        check_eq("pc31_unmask", 32'(irq_seen), 32'd1);
        wr_reg(STATUS_A, 32'd1);
        rd_chk("w1c_status", STATUS_A, 32'd0);
        check_eq("w1c_irq", 32'(irq_seen), 32'd0);

        // One-shot on channel 1.
        wr_reg(ch_a(1, 0), 32'h0000_1234);
        wr_reg(ch_a(1, 1), 32'hFFFF_FFFF);
        wr_reg(ch_a(1, 2), 32'd5);
        for (int i = 0; i < N_CH; i++) tick_cnt[i] = 0;
        idle(5);
        check_eq("os_tick_cnt", 32'(tick_cnt[1]), 32'd1);
        rd_chk("os_tcon", ch_a(1, 2), 32'd4);
        rd_chk("os_tl", ch_a(1, 1), 32'h0000_1234);
        wr_reg(STATUS_A, 32'd2);

        // W1C coinciding with the overflow cycle of channel 2.
        wr_reg(ch_a(2, 0), 32'd0);
        wr_reg(ch_a(2, 1), 32'hFFFF_FFFE);
        wr_reg(ch_a(2, 2), 32'd1);
        idle(1);
        wr_reg(STATUS_A, 32'd4);
        check_eq("w1c_race_tick", 32'(tick_seen[2]), 32'd1);
        rd_chk("w1c_race_status", STATUS_A, 32'd4);
        wr_reg(ch_a(2, 2), 32'd0);
        wr_reg(STATUS_A, 32'd4);

        // Prescaler on channel 3.
        wr_reg(ch_a(3, 3), 32'd2);
        wr_reg(ch_a(3, 1), 32'd0);
`ifdef TIMER_PRESCALER_EN
        wr_reg(ch_a(3, 2), 32'd1);
        idle(3);
        rd_chk("psc_tl1", ch_a(3, 1), 32'd1);
        idle(2);
        rd_chk("psc_tl2", ch_a(3, 1), 32'd2);
`else
        rd_chk("psc_reads0", ch_a(3, 3), 32'd0);
        wr_reg(ch_a(3, 2), 32'd1);
        rd_chk("nopsc_tl0", ch_a(3, 1), 32'd0);
        rd_chk("nopsc_tl1", ch_a(3, 1), 32'd1);
`endif
        wr_reg(ch_a(3, 2), 32'd0);

        // Reset mid-count with a write pending in the reset cycle.
        wr_reg(ch_a(0, 1), 32'hFFFF_FFF0);
        wr_reg(ch_a(0, 2), 32'd3);
        idle(2);
        apply_reset(1'b1, ch_a(0, 1), 32'd5);
        idle(1);
        check_eq("post_rst_irq", 32'(irq_seen), 32'd0);
        check_eq("post_rst_tick", 32'(tick_seen), 32'd0);
        check_all_zero("post_rst_regs");

        // Random traffic against the model.
        for (int n = 0; n < 2500; n++) begin
            pc_31 = ($urandom_range(0, 3) == 0);
            k  = $urandom_range(0, 99);
            ch = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 7) : $urandom_range(0, N_CH - 1);
            r  = $urandom_range(0, 3);
            a  = ch_a(ch, r);
            case (r)
                0, 1:    d = $urandom_range(0, 1) ? CNT_MASK - 32'($urandom_range(0, 12)) : $urandom;
                2:       d = 32'($urandom_range(0, 7)) | ($urandom_range(0, 1) ? ($urandom & 32'hFFFF_FFF8) : 32'd0);
                default: d = 32'($urandom_range(0, 3));
            endcase
            if (k < 2)       apply_reset(1'b1, a, d);
            else if (k < 10) cycle(1'($urandom_range(0, 1)), 1'b1, STATUS_A, $urandom);
            else if (k < 40) cycle(1'b0, 1'b1, a, d);
            else if (k < 72) cycle(1'b1, 1'b0, ($urandom_range(0, 9) == 0) ? STATUS_A : a, 32'd0);
            else if (k < 76) cycle(1'($urandom_range(0, 1)), 1'b1, 32'h4000_0000 + 32'(4 * $urandom_range(0, 255)), $urandom);
            else             cycle(1'b0, 1'b0, 32'd0, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_bank.md
TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of timer channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 32, counter/reload width in bits (8..32).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h40000100, byte address of channel 0.
REQ-004 SHALL have port sysclk  input  1  system clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous active-low reset.
REQ-006 SHALL have port rd  input  1  read strobe.
REQ-007 SHALL have port wr  input  1  write strobe.
REQ-008 SHALL have port addr  input  32  byte address.
REQ-009 SHALL have port wdata  input  32  write data.
REQ-010 SHALL have port rdata  output  32  read data.
REQ-011 SHALL have port PC_31  input  1  supervisor flag; 1 masks irqout.
REQ-012 SHALL have port irqout  output  1  interrupt request.
REQ-013 SHALL have port tick  output  N_CH  per-channel one-cycle overflow pulse.

Function
REQ-014 SHALL map channel i at BASE_ADDR+16*i: +0 TH (reload), +4 TL (count), +8 TCON, +C PSC; BASE_ADDR+0x80 STATUS.
REQ-015 SHALL define TCON bits: [0] en, [1] irq_en, [2] oneshot; upper bits read 0.
REQ-016 SHALL drive rdata combinationally (zero latency), zero-extended, 0 when rd=0 or address unmapped/channel >= N_CH.
REQ-017 SHALL, when en=1 and channel tick-enable asserted, increment TL by 1 per cycle modulo 2^CNT_W.
REQ-018 SHALL, when TL = all-ones and incrementing, load TL <= TH, set STATUS[i], pulse tick[i] for exactly that cycle.
REQ-019 SHALL, on overflow with oneshot=1, clear en in the same cycle (TL still reloads).
REQ-020 SHALL treat STATUS as write-1-to-clear; bits >= N_CH read 0 and ignore writes.
REQ-021 SHALL give overflow-set priority over W1C clear of the same bit in the same cycle.
REQ-022 SHALL give bus write to TL or TCON priority over same-cycle increment/reload/oneshot-clear of that channel.
REQ-023 SHALL drive irqout = ~PC_31 & OR over i of (STATUS[i] & irq_en[i]), combinational.
REQ-024 SHALL truncate wdata to CNT_W for TH/TL writes; reads zero-extend.
REQ-025 SHALL ignore wr with unmapped address; simultaneous rd and wr to STATUS returns pre-clear value.

Reset
REQ-026 SHALL, on rising sysclk with reset=0, clear TH, TL, TCON, PSC, prescale counters, STATUS and tick to 0.
REQ-027 SHALL discard any pending overflow or write in a reset cycle; irqout SHALL be 0 in the cycle after reset.

Configuration
REQ-028 SHALL, with TIMER_PRESCALER_EN defined, provide 16-bit PSC per channel: TL advances once every PSC+1 enabled cycles; prescale counter clears on TCON or PSC write.
REQ-029 SHALL, without TIMER_PRESCALER_EN, read PSC as 0, ignore PSC writes, advance TL every enabled cycle.

Structure
REQ-030 SHALL place register offsets, TCON bit indices and STATUS offset in shared package timer_pkg.
REQ-031 SHALL instantiate N_CH copies of sub-module timer_channel (TH/TL/TCON/PSC, prescaler, overflow detect); top holds decode, STATUS, rdata mux, irqout.

Verification
REQ-032 SHALL test: TH=0xFFFFFFFC, TL=0xFFFFFFFC, TCON=3 -> tick[0] and STATUS[0] after 4 cycles, TL=0xFFFFFFFC, irqout=1 while PC_31=0.
REQ-033 SHALL test: same with PC_31=1 -> irqout=0; write STATUS=1 -> STATUS=0, irqout=0.
REQ-034 SHALL test: TCON=5 (oneshot) on ch1, TL=0xFFFFFFFF -> single tick[1], TCON reads 4, TL holds TH.
REQ-035 SHALL test: W1C STATUS coinciding with overflow cycle -> STATUS bit remains 1.
REQ-036 SHALL test: TIMER_PRESCALER_EN, PSC=2, TL=0 -> TL=1 after 3 cycles, 2 after 6; without macro PSC reads 0.
REQ-037 SHALL test: reset=0 mid-count for one edge -> all registers read 0, irqout=0, tick=0.
